ex_muldiv_seq: RTL and testbench

Multi-cycle sequencer for RV32M multiply/divide operations in the EX stage. It accepts one M-extension operation from the ID/EX register. While the operation runs, it holds the pipeline by asserting a stall. It iterates a shared shift/add-subtract datapath for 32 cycles and presents a one-cycle `done_o` with the result, which the EX stage muxes in place of the ALU output. It sits beside the single-cycle ALU, and the EX/MEM register captures its result in the `done_o` cycle.

---
 rtl/ex_muldiv_seq.sv | 165 ++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M sequencer for the EX stage: shift/add multiply and restoring divide,
// one bit per cycle, with a one-cycle done pulse and a pipeline stall while busy.
module ex_muldiv_seq #(
  parameter int unsigned BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [BIT_W-1:0] opA,
  input  logic [BIT_W-1:0] opB,
  input  logic             flush,
  output logic             stall_o,
  output logic             done_o,
  output logic [BIT_W-1:0] result_o
);

  localparam int unsigned CntW = $clog2(BIT_W) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BIT_W - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             state_q, state_d;
  logic [2*BIT_W-1:0] acc_q, acc_d;
  logic [BIT_W-1:0]   opd_q, opd_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         fn_q, fn_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [BIT_W-1:0]   result_q, result_d;

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [BIT_W-1:0]   abs_a, abs_b;
  logic               div_zero, div_ovf;

  logic [BIT_W:0]     add_sum;
  logic [2*BIT_W-1:0] mul_acc_nxt, prod_fix;
  logic [BIT_W-1:0]   mul_res;
  logic [BIT_W:0]     div_shift, div_diff;
  logic               q_bit;
  logic [2*BIT_W-1:0] div_acc_nxt;
  logic [BIT_W-1:0]   quo, rem, div_res;

  // Operand conditioning, evaluated against the live ID/EX inputs in IDLE.
  always_comb begin
    a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
    b_signed = a_signed && (op != 3'b010);
    a_neg    = a_signed && opA[BIT_W-1];
    b_neg    = b_signed && opB[BIT_W-1];
    abs_a    = a_neg ? -opA : opA;
    abs_b    = b_neg ? -opB : opB;
    div_zero = op[2] && (opB == '0);
    div_ovf  = op[2] && !op[0] && (opA == {1'b1, {(BIT_W-1){1'b0}}}) && (opB == '1);
  end

  // Multiply step: conditional add into the upper half, then shift right with carry-in.
  always_comb begin
    add_sum     = {1'b0, acc_q[2*BIT_W-1:BIT_W]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_acc_nxt = {add_sum, acc_q[BIT_W-1:1]};
    prod_fix    = neg_q ? -mul_acc_nxt : mul_acc_nxt;
    mul_res     = (fn_q == 2'b00) ? prod_fix[BIT_W-1:0] : prod_fix[2*BIT_W-1:BIT_W];
  end

  // Divide step: upper half is the partial remainder, lower half shifts dividend out
  // and quotient in. A clear borrow bit means the shifted remainder covers the divisor.
  always_comb begin
    div_shift   = {acc_q[2*BIT_W-1:BIT_W], acc_q[BIT_W-1]};
    div_diff    = div_shift - {1'b0, opd_q};
    q_bit       = ~div_diff[BIT_W];
    div_acc_nxt = {(q_bit ? div_diff[BIT_W-1:0] : div_shift[BIT_W-1:0]),
                   acc_q[BIT_W-2:0], q_bit};
    quo         = div_acc_nxt[BIT_W-1:0];
    rem         = div_acc_nxt[2*BIT_W-1:BIT_W];
    div_res     = fn_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          fn_d   = op[1:0];
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          if (!op[2]) begin
            acc_d   = {{BIT_W{1'b0}}, abs_b};
            opd_d   = abs_a;
            state_d = StMul;
          end else if (div_zero) begin
            result_d = op[1] ? opA : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = op[1] ? '0 : opA;
            state_d  = StDone;
          end else begin
            acc_d   = {{BIT_W{1'b0}}, abs_a};
            opd_d   = abs_b;
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        acc_d = mul_acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          result_d = mul_res;
          state_d  = StDone;
        end
      end
      StDiv: begin
        acc_d = div_acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          result_d = div_res;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A killed op must leave result_o untouched, even on its final iteration.
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      opd_q    <= '0;
      cnt_q    <= '0;
      fn_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = rst_n && ((state_q == StIdle && start && !flush) ||
                              state_q == StMul || state_q == StDiv);
  assign done_o   = (state_q == StDone) && !flush;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: latency, stall window, results, flush and reset abort.
module tb_ex_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_res = '0;

  ex_muldiv_seq #(.BIT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .opA      (opA),
    .opB      (opB),
    .flush    (flush),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one op starting in the current cycle (caller is just past a posedge) and
  // follows it to done_o; returns just past the posedge that ends the DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit drop_start);
    int          done_cyc;
    logic [31:0] res;
    bit          stall_ok;
    logic        stall_done;
    done_cyc   = -1;
    res        = 'x;
    stall_ok   = 1'b1;
    stall_done = 1'bx;
    start = 1'b1;
    op    = o;
    opA   = a;
    opB   = b;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_o) begin
        done_cyc   = c;
        res        = result_o;
        stall_done = stall_o;
      end else if (!stall_o) begin
        stall_ok = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0) break;
    end
    if (drop_start) start = 1'b0;
    check({tag, " latency"}, done_cyc, exp_lat);
    check({tag, " result"}, res, exp);
    check({tag, " stall window"}, stall_ok, 1);
    check({tag, " stall in done"}, stall_done, 0);
    last_res = exp;
  endtask

  // One idle cycle after an op: done must not repeat and nothing stalls.
  task automatic idle_cycle(input string tag);
    @(negedge clk);
    check({tag, " single done"}, done_o, 0);
    check({tag, " idle stall"}, stall_o, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int extra_done;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    opA   = '0;
    opB   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", stall_o, 0);
    check("reset done", done_o, 0);
    check("reset result", result_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
    idle_cycle("MUL");
    run_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b1);
    idle_cycle("MULH");
    run_op("MULHU", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b1);
    idle_cycle("MULHU");
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1);
    idle_cycle("MULHSU");
    run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
    idle_cycle("DIV");
    run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
    idle_cycle("REM");
    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    idle_cycle("DIVU");
    run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    idle_cycle("REMU");
    run_op("DIVU by 0", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    idle_cycle("DIVU0");
    run_op("REMU by 0", 3'b111, 32'd100, 32'd0, 32'd100, 1, 1'b1);
    idle_cycle("REMU0");
    run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    idle_cycle("DIVOVF");
    run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
    idle_cycle("REMOVF");

    // Flush a DIVU 1000/10 in cycle 10, then start MUL 3*5 in cycle 11.
    start = 1'b1;
    op    = 3'b101;
    opA   = 32'd1000;
    opB   = 32'd10;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush done", done_o, 0);
    check("flush result", result_o, last_res);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("post-flush result", result_o, last_res);
    run_op("MUL 3*5 after flush", 3'b000, 32'd3, 32'd5, 32'd15, 33, 1'b1);
    idle_cycle("MUL after flush");

    // Reset in cycle 5 of a MUL.
    start = 1'b1;
    op    = 3'b000;
    opA   = 32'h1234;
    opB   = 32'h10;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("abort stall", stall_o, 0);
    check("abort done", done_o, 0);
    check("abort result", result_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    extra_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) extra_done++;
    end
    check("no done after abort", extra_done, 0);
    @(posedge clk);
    #1;

    // Back-to-back: DIVU accepted in the cycle right after the MUL's DONE.
    run_op("B2B MUL 2*3", 3'b000, 32'd2, 32'd3, 32'd6, 33, 1'b0);
    run_op("B2B DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 33, 1'b1);
    idle_cycle("B2B");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
